// File: rtl/pmipsl0.sv
// pmipsl0: single-cycle 16-bit MIPS-like core with 17-bit instructions and eight 16-bit registers.
// Each instruction is fetched and executed in one cycle; PC and register writes commit on the rising clock edge.
module pmipsl0 (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] imemaddr,
  output logic [15:0] dmemaddr,
  output logic [15:0] dmemwdata,
  output logic        dmemwrite,
  output logic        dmemread,
  output logic [15:0] aluresult,
  input  logic [16:0] imemrdata,
  input  logic [15:0] dmemrdata,
  output logic [15:0] probe1,
  output logic [15:0] probe2,
  output logic [15:0] probe3
);

  logic [15:0] r_pc;
  logic [15:0] r_regs [8];

  logic [3:0]  w_op;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic [2:0]  w_rd;
  logic [3:0]  w_funct;
  logic [15:0] w_sext;
  logic [15:0] w_zext;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_alu;
  logic [15:0] w_pc2;
  logic [15:0] w_npc;
  logic        w_we;
  logic [2:0]  w_wa;
  logic [15:0] w_wd;

  assign w_op    = imemrdata[16:13];
  assign w_rs    = imemrdata[12:10];
  assign w_rt    = imemrdata[9:7];
  assign w_rd    = imemrdata[6:4];
  assign w_funct = imemrdata[3:0];
  assign w_sext  = {{9{imemrdata[6]}}, imemrdata[6:0]};
  assign w_zext  = {9'd0, imemrdata[6:0]};

  // Entry 0 is cleared at reset and never written, so it always reads zero.
  assign w_a = r_regs[w_rs];
  assign w_b = r_regs[w_rt];

  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd0: begin
        case (w_funct)
          4'd0:    w_alu = w_a + w_b;
          4'd1:    w_alu = w_a - w_b;
          4'd2:    w_alu = w_a & w_b;
          4'd3:    w_alu = w_a | w_b;
          4'd4:    w_alu = {15'd0, $signed(w_a) < $signed(w_b)};
          default: w_alu = '0;
        endcase
      end
      4'd2, 4'd3:       w_alu = w_a - w_b;
      4'd4, 4'd5, 4'd6: w_alu = w_a + w_sext;
      4'd7:             w_alu = w_a & w_zext;
      default:          w_alu = '0;
    endcase
  end

  assign w_pc2 = r_pc + 16'd2;

  always_comb begin
    w_npc = w_pc2;
    case (w_op)
      4'd1: w_npc = {w_pc2[15:14], imemrdata[12:0], 1'b0};
      4'd2: if (w_alu == 16'd0) w_npc = w_pc2 + (w_sext << 1);
      4'd3: if (w_alu != 16'd0) w_npc = w_pc2 + (w_sext << 1);
      default: w_npc = w_pc2;
    endcase
  end

  always_comb begin
    w_we = 1'b0;
    w_wa = w_rt;
    w_wd = w_alu;
    case (w_op)
      4'd0: begin
        w_wa = w_rd;
        w_we = (w_funct <= 4'd4);
      end
      4'd4: begin
        w_we = 1'b1;
        w_wd = dmemrdata;
      end
      4'd6, 4'd7: w_we = 1'b1;
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_npc;
      if (w_we && (w_wa != 3'd0)) r_regs[w_wa] <= w_wd;
    end
  end

  assign imemaddr  = r_pc;
  assign aluresult = w_alu;
  assign dmemaddr  = w_alu;
  assign dmemwdata = w_b;
  // Strobes are forced low while reset is held so no device sees a stray access.
  assign dmemread  = reset && (w_op == 4'd4);
  assign dmemwrite = reset && (w_op == 4'd5);
  assign probe1    = r_regs[5];
  assign probe2    = r_regs[6];
  assign probe3    = r_regs[7];

endmodule

// File: tb/tb_pmipsl0.sv
// Bench for pmipsl0: directed program plus random instructions checked against an ISA-level model.
module tb_pmipsl0;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] imemaddr, dmemaddr, dmemwdata, aluresult, dmemrdata;
  logic [15:0] probe1, probe2, probe3;
  logic        dmemwrite, dmemread;
  logic [16:0] imemrdata;

  logic [15:0] dmem [16];
  logic [15:0] m_reg [8];
  logic [15:0] m_pc;
  int checks = 0;
  int errors = 0;

  assign dmemrdata = dmem[dmemaddr[3:0]];
  always #5 clock = ~clock;

  pmipsl0 dut (
    .clock(clock), .reset(reset), .imemaddr(imemaddr), .dmemaddr(dmemaddr),
    .dmemwdata(dmemwdata), .dmemwrite(dmemwrite), .dmemread(dmemread),
    .aluresult(aluresult), .imemrdata(imemrdata), .dmemrdata(dmemrdata),
    .probe1(probe1), .probe2(probe2), .probe3(probe3)
  );

  function automatic logic [16:0] enc_i(int op, int rs, int rt, int imm);
    return {4'(op), 3'(rs), 3'(rt), 7'(imm)};
  endfunction

  function automatic logic [16:0] enc_r(int rs, int rt, int rd, int fn);
    return {4'd0, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
  endtask

  // Apply one instruction, compare every output against the ISA rules, then commit one edge.
  task automatic step(input logic [16:0] ins);
    int op, rs, rt, rd, fn, simm, wa;
    logic [15:0] a, b, alu, npc, wd;
    bit alu_ok, wr, mw;
    logic [3:0] mwa;
    logic [15:0] mwd;
    imemrdata = ins;
    #1;
    op = int'(ins[16:13]); rs = int'(ins[12:10]); rt = int'(ins[9:7]);
    rd = int'(ins[6:4]);   fn = int'(ins[3:0]);
    simm = int'(ins[6:0]);
    if (simm > 63) simm -= 128;
    a = m_reg[rs]; b = m_reg[rt];
    npc = 16'(int'(m_pc) + 2);
    alu = '0; alu_ok = 1; wr = 0; wa = rt; wd = '0;
    case (op)
      0: begin
        wa = rd;
        wr = (fn <= 4);
        case (fn)
          0: alu = 16'(int'(a) + int'(b));
          1: alu = 16'(int'(a) - int'(b));
          2: alu = a & b;
          3: alu = a | b;
          4: alu = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          default: alu_ok = 0;
        endcase
        wd = alu;
      end
      1: begin
        alu_ok = 0;
        npc = 16'((int'(npc) & 'hC000) + int'(ins[12:0]) * 2);
      end
      2, 3: begin
        alu = 16'(int'(a) - int'(b));
        if ((a == b) == (op == 2)) npc = 16'(int'(m_pc) + 2 + 2 * simm);
      end
      4: begin alu = 16'(int'(a) + simm); wr = 1; wd = dmem[alu[3:0]]; end
      5: alu = 16'(int'(a) + simm);
      6: begin alu = 16'(int'(a) + simm); wr = 1; wd = alu; end
      7: begin alu = a & 16'(ins[6:0]); wr = 1; wd = alu; end
      default: alu_ok = 0;
    endcase
    chk("pc", imemaddr, m_pc);
    chk("dmemread", {15'd0, dmemread}, 16'(op == 4));
    chk("dmemwrite", {15'd0, dmemwrite}, 16'(op == 5));
    chk("dmemwdata", dmemwdata, b);
    if (alu_ok) begin
      chk("aluresult", aluresult, alu);
      chk("dmemaddr", dmemaddr, alu);
    end
    chk("probe1", probe1, m_reg[5]);
    chk("probe2", probe2, m_reg[6]);
    chk("probe3", probe3, m_reg[7]);
    mw = dmemwrite; mwa = dmemaddr[3:0]; mwd = dmemwdata;
    @(posedge clock);
    #1;
    if (mw) dmem[mwa] = mwd;
    if (wr && wa != 0) m_reg[wa] = wd;
    m_pc = npc;
  endtask

  task automatic lit_alu(input string nm, input logic [16:0] ins, input logic [15:0] exp);
    imemrdata = ins;
    #1;
    chk(nm, aluresult, exp);
  endtask

  function automatic logic [16:0] rand_ins();
    int op;
    op = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
    if (op == 0)
      return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 6));
    return {4'(op), 13'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = 16'($urandom);
    model_reset();
    reset = 1'b0;
    imemrdata = enc_i(5, 0, 5, 2);
    #1;
    chk("rst_pc", imemaddr, 16'd0);
    chk("rst_dmemwrite", {15'd0, dmemwrite}, 16'd0);
    chk("rst_probe1", probe1, 16'd0);
    #1 reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      chk("pc_seq", imemaddr, 16'(2 * i));
      lit_alu("addi_alu", enc_i(6, 0, 5, 3), 16'd3);
      step(enc_i(6, 0, 5, 3));
      chk("addi_probe1", probe1, 16'd3);
    end
    lit_alu("andi_alu", enc_i(7, 5, 6, 1), 16'd1);
    step(enc_i(7, 5, 6, 1));
    chk("andi_probe2", probe2, 16'd1);
    chk("andi_probe1", probe1, 16'd3);
    lit_alu("addi_r0_alu", enc_i(6, 0, 0, 7), 16'd7);
    step(enc_i(6, 0, 0, 7));
    step(enc_r(0, 0, 7, 0));
    chk("r0_zero_probe3", probe3, 16'd0);
    step(enc_i(6, 0, 3, 5));
    lit_alu("slt_a", enc_r(3, 0, 4, 4), 16'd0);
    step(enc_r(3, 0, 4, 4));
    lit_alu("slt_b", enc_r(0, 3, 4, 4), 16'd1);
    step(enc_r(0, 3, 4, 4));
    imemrdata = enc_i(5, 0, 5, 2);
    #1;
    chk("sw_strobe", {15'd0, dmemwrite}, 16'd1);
    chk("sw_addr", dmemaddr, 16'd2);
    chk("sw_wdata", dmemwdata, 16'd3);
    step(enc_i(5, 0, 5, 2));
    imemrdata = enc_i(4, 0, 7, 2);
    #1;
    chk("lw_strobe", {15'd0, dmemread}, 16'd1);
    step(enc_i(4, 0, 7, 2));
    chk("lw_probe3", probe3, 16'd3);
    chk("pc_before_j", imemaddr, 16'd26);
    step({4'd1, 13'd5});
    chk("j_pc", imemaddr, 16'd10);
    step(enc_i(2, 0, 0, -2));
    chk("beq_pc", imemaddr, 16'd8);
    step(enc_i(3, 0, 0, -2));
    chk("bne_pc", imemaddr, 16'd10);

    for (int i = 0; i < 300; i++) step(rand_ins());

    imemrdata = enc_i(5, 0, 5, 2);
    reset = 1'b0;
    #1;
    chk("midrst_pc", imemaddr, 16'd0);
    chk("midrst_probe1", probe1, 16'd0);
    chk("midrst_probe2", probe2, 16'd0);
    chk("midrst_probe3", probe3, 16'd0);
    chk("midrst_dmemwrite", {15'd0, dmemwrite}, 16'd0);
    imemrdata = enc_i(6, 0, 5, 9);
    @(posedge clock);
    #1;
    chk("midrst_noexec_probe1", probe1, 16'd0);
    chk("midrst_hold_pc", imemaddr, 16'd0);
    model_reset();
    reset = 1'b1;

    for (int i = 0; i < 300; i++) step(rand_ins());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
